sel_stats_window: RTL and testbench

//  Downstream consumer of the priority-select stage (y = c/e/g/j/k chosen by the a==b, d>20,
//  f>40, h==i cascade). Accepts one selected result plus its branch code per handshake, and

---
 rtl/sel_stats_window.sv | 125 ++++++++++++
 tb/tb_sel_stats_window.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/sel_stats_window.sv
// rtl/sel_stats_window.sv - windowed signed min/max/sum and branch histogram over select-stage results
// Collects WIN samples, then holds one summary record until the consumer takes it.
module sel_stats_window #(
  parameter int DATA_W = 32,
  parameter int WIN    = 10,
  parameter int SUM_W  = 36,
  parameter int HIST_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_W-1:0]     y_in,
  input  logic [2:0]            branch_id,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  stat_valid,
  input  logic                  stat_ready,
  output logic [DATA_W-1:0]     stat_min,
  output logic [DATA_W-1:0]     stat_max,
  output logic [SUM_W-1:0]      stat_sum,
  output logic [5*HIST_W-1:0]   stat_hist,
  output logic                  err_branch
);

  localparam int CNT_W = 5;

  typedef enum logic {S_ACCUM, S_HOLD} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    count_q;
  logic [DATA_W-1:0]   run_min_q, run_max_q;
  logic [SUM_W-1:0]    run_sum_q;
  logic [HIST_W-1:0]   hist_q [5];
  logic [DATA_W-1:0]   stat_min_q, stat_max_q;
  logic [SUM_W-1:0]    stat_sum_q;
  logic [5*HIST_W-1:0] stat_hist_q;
  logic                err_q;

  logic                accept, xfer, last, first;
  logic [DATA_W-1:0]   min_upd, max_upd;
  logic [SUM_W-1:0]    y_sext, sum_upd;
  logic [HIST_W-1:0]   hist_upd [5];
  logic [5*HIST_W-1:0] hist_pack;

  assign accept = in_valid & in_ready;
  assign xfer   = stat_valid & stat_ready;
  assign last   = accept && (count_q == CNT_W'(WIN - 1));
  assign first  = (count_q == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_ACCUM;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_ACCUM: if (last) state_d = S_HOLD;
      S_HOLD:  if (xfer) state_d = S_ACCUM;
      default: state_d = S_ACCUM;
    endcase
  end

  // Handshakes decode only the registered state, so no sample slips in on the transfer cycle.
  always_comb begin
    in_ready   = (state_q == S_ACCUM);
    stat_valid = (state_q == S_HOLD);
  end

  always_comb begin
    y_sext  = {{(SUM_W-DATA_W){y_in[DATA_W-1]}}, y_in};
    min_upd = (first || ($signed(y_in) < $signed(run_min_q))) ? y_in : run_min_q;
    max_upd = (first || ($signed(y_in) > $signed(run_max_q))) ? y_in : run_max_q;
    sum_upd = first ? y_sext : run_sum_q + y_sext;
    hist_pack = '0;
    for (int n = 0; n < 5; n++) begin
      hist_upd[n] = hist_q[n];
      if ((branch_id == 3'(n)) && (hist_q[n] != '1))
        hist_upd[n] = hist_q[n] + HIST_W'(1);
      hist_pack[n*HIST_W +: HIST_W] = hist_upd[n];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q     <= '0;
      run_min_q   <= '0;
      run_max_q   <= '0;
      run_sum_q   <= '0;
      for (int n = 0; n < 5; n++) hist_q[n] <= '0;
      stat_min_q  <= '0;
      stat_max_q  <= '0;
      stat_sum_q  <= '0;
      stat_hist_q <= '0;
      err_q       <= 1'b0;
    end else begin
      if (xfer) begin
        count_q   <= '0;
        run_min_q <= '0;
        run_max_q <= '0;
        run_sum_q <= '0;
        for (int n = 0; n < 5; n++) hist_q[n] <= '0;
      end else if (accept) begin
        count_q   <= count_q + CNT_W'(1);
        run_min_q <= min_upd;
        run_max_q <= max_upd;
        run_sum_q <= sum_upd;
        for (int n = 0; n < 5; n++) hist_q[n] <= hist_upd[n];
      end
      if (last) begin
        stat_min_q  <= min_upd;
        stat_max_q  <= max_upd;
        stat_sum_q  <= sum_upd;
        stat_hist_q <= hist_pack;
      end
      if (accept && (branch_id > 3'd4)) err_q <= 1'b1;
    end
  end

  assign stat_min   = stat_min_q;
  assign stat_max   = stat_max_q;
  assign stat_sum   = stat_sum_q;
  assign stat_hist  = stat_hist_q;
  assign err_branch = err_q;

endmodule

// File: tb/tb_sel_stats_window.sv
// tb/tb_sel_stats_window.sv - scoreboard bench for sel_stats_window
// Model pushes expected window records on accept; a negedge monitor compares them on output.
module tb_sel_stats_window;

  localparam int DATA_W = 32;
  localparam int WIN    = 10;
  localparam int SUM_W  = 36;
  localparam int HIST_W = 5;

  logic                clk;
  logic                rst_n;
  logic [DATA_W-1:0]   y_in;
  logic [2:0]          branch_id;
  logic                in_valid;
  logic                in_ready;
  logic                stat_valid;
  logic                stat_ready;
  logic [DATA_W-1:0]   stat_min;
  logic [DATA_W-1:0]   stat_max;
  logic [SUM_W-1:0]    stat_sum;
  logic [5*HIST_W-1:0] stat_hist;
  logic                err_branch;

  sel_stats_window #(.DATA_W(DATA_W), .WIN(WIN), .SUM_W(SUM_W), .HIST_W(HIST_W)) dut (
    .clk(clk), .rst_n(rst_n), .y_in(y_in), .branch_id(branch_id),
    .in_valid(in_valid), .in_ready(in_ready), .stat_valid(stat_valid),
    .stat_ready(stat_ready), .stat_min(stat_min), .stat_max(stat_max),
    .stat_sum(stat_sum), .stat_hist(stat_hist), .err_branch(err_branch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [DATA_W-1:0]   mn;
    logic [DATA_W-1:0]   mx;
    logic [SUM_W-1:0]    sm;
    logic [5*HIST_W-1:0] hs;
  } rec_t;

  rec_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  int     m_cnt = 0;
  longint m_min, m_max, m_sum;
  int     m_hist [5];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic model_accept(input int y, input int bid);
    rec_t r;
    if (m_cnt == 0) begin
      m_min = y; m_max = y; m_sum = y;
      for (int n = 0; n < 5; n++) m_hist[n] = 0;
    end else begin
      if (y < m_min) m_min = y;
      if (y > m_max) m_max = y;
      m_sum += y;
    end
    if (bid < 5) m_hist[bid]++;
    m_cnt++;
    if (m_cnt == WIN) begin
      r.mn = DATA_W'(m_min);
      r.mx = DATA_W'(m_max);
      r.sm = SUM_W'(m_sum);
      r.hs = '0;
      for (int n = 0; n < 5; n++) r.hs[n*HIST_W +: HIST_W] = HIST_W'(m_hist[n]);
      exp_q.push_back(r);
      m_cnt = 0;
    end
  endtask

  task automatic send(input int y, input int bid);
    int n = 0;
    @(negedge clk);
    y_in = DATA_W'(y);
    branch_id = 3'(bid);
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("send_timeout", 64'(n), 64'(0));
    @(posedge clk);
    model_accept(y, bid);
  endtask

  // Monitor samples just after the negedge so same-edge driver updates are already visible.
  always begin
    @(negedge clk);
    #1;
    if (rst_n && stat_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_record", 64'(1), 64'(0));
      end else begin
        check("rec_min",  64'(stat_min),  64'(exp_q[0].mn));
        check("rec_max",  64'(stat_max),  64'(exp_q[0].mx));
        check("rec_sum",  64'(stat_sum),  64'(exp_q[0].sm));
        check("rec_hist", 64'(stat_hist), 64'(exp_q[0].hs));
        check("hold_in_ready", 64'(in_ready), 64'(0));
        if (stat_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  int y1 [10] = '{12, 45, 19, 40, 36, 28, 27, 22, 14, 33};
  int b1 [10] = '{1, 4, 1, 0, 1, 1, 1, 4, 1, 1};

  initial begin
    rst_n = 1'b0; in_valid = 1'b1; y_in = 32'd55; branch_id = 3'd1; stat_ready = 1'b1;

    // Reset held two cycles with in_valid asserted
    @(negedge clk);
    @(negedge clk);
    check("rst_in_ready",   64'(in_ready),   64'(1));
    check("rst_stat_valid", 64'(stat_valid), 64'(0));
    check("rst_min",        64'(stat_min),   64'(0));
    check("rst_max",        64'(stat_max),   64'(0));
    check("rst_sum",        64'(stat_sum),   64'(0));
    check("rst_hist",       64'(stat_hist),  64'(0));
    check("rst_err",        64'(err_branch), 64'(0));
    rst_n = 1'b1; in_valid = 1'b0;

    // Reference window, back to back
    for (int i = 0; i < 10; i++) send(y1[i], b1[i]);
    @(negedge clk);
    in_valid = 1'b0;
    check("w1_latency", 64'(stat_valid), 64'(1));
    check("w1_min",  64'(stat_min),  64'(12));
    check("w1_max",  64'(stat_max),  64'(45));
    check("w1_sum",  64'(stat_sum),  64'(276));
    check("w1_hist", 64'(stat_hist), 64'({5'd2, 5'd0, 5'd0, 5'd7, 5'd1}));
    @(negedge clk);
    check("w1_pulse", 64'(stat_valid), 64'(0));
    check("w1_ready", 64'(in_ready),   64'(1));

    // Backpressure: record held while upstream pushes garbage
    stat_ready = 1'b0;
    for (int i = 0; i < 10; i++) send(3, 3);
    @(negedge clk);
    in_valid = 1'b1; y_in = 32'd999; branch_id = 3'd0;
    check("bp_valid", 64'(stat_valid), 64'(1));
    repeat (4) begin
      @(negedge clk);
      check("bp_in_ready", 64'(in_ready), 64'(0));
    end
    @(negedge clk);
    stat_ready = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    check("bp_release_ready", 64'(in_ready),   64'(1));
    check("bp_release_valid", 64'(stat_valid), 64'(0));
    for (int i = 0; i < 10; i++) send(-5, 0);
    @(negedge clk);
    in_valid = 1'b0;
    check("neg_min", 64'(stat_min), 64'(32'hFFFF_FFFB));
    check("neg_sum", 64'(stat_sum), 64'(36'hF_FFFF_FFCE));
    @(negedge clk);

    // Illegal branch id inside a window
    for (int i = 0; i < 10; i++) send(20, (i == 4) ? 6 : 2);
    @(negedge clk);
    in_valid = 1'b0;
    check("ill_err",  64'(err_branch), 64'(1));
    check("ill_sum",  64'(stat_sum),   64'(200));
    check("ill_hist", 64'(stat_hist),  64'({5'd0, 5'd0, 5'd9, 5'd0, 5'd0}));
    @(negedge clk);

    // Gapped input: idle cycle between accepts
    for (int i = 0; i < 10; i++) begin
      send(i * 3 - 4, i % 5);
      @(negedge clk);
      in_valid = 1'b0;
    end
    repeat (2) @(negedge clk);
    check("gap_err_sticky", 64'(err_branch), 64'(1));

    // Reset mid-window discards the partial window
    for (int i = 0; i < 4; i++) send(100, 1);
    @(negedge clk);
    in_valid = 1'b0; rst_n = 1'b0;
    m_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    check("mid_rst_err",   64'(err_branch), 64'(0));
    check("mid_rst_sum",   64'(stat_sum),   64'(0));
    check("mid_rst_ready", 64'(in_ready),   64'(1));
    for (int i = 0; i < 10; i++) send(7, 3);
    @(negedge clk);
    in_valid = 1'b0;
    check("mid_sum", 64'(stat_sum), 64'(70));
    check("mid_min", 64'(stat_min), 64'(7));
    check("mid_max", 64'(stat_max), 64'(7));
    repeat (3) @(negedge clk);

    check("records_drained", 64'(exp_q.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
